ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
Execute stage of the 5-stage MIPS pipeline. It consumes the registered ID/EX operation bundle and computes the writeback value for ex_mem. It owns the architectural HI/LO registers and a 32-iteration radix-2 divider FSM. During a divide it raises stallreq so the upstream stages hold the instruction.

Parameters:
DIV_ITERS, 32, divider iterations (one quotient bit per cycle; fixed to operand width)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
flush  in  1  annul instruction in EX; aborts divider
aluop_i  in  8  sub-operation (`AluOpBus)
alusel_i  in  3  operation class (`AluSelBus)
reg1_i  in  32  operand 1 (shift amount in [4:0] for shifts)
reg2_i  in  32  operand 2 (shift source for shifts)
wd_i  in  5  destination register address
wreg_i  in  1  destination write enable
wd_o  out  5  destination to ex_mem
wreg_o  out  1  write enable to ex_mem
wdata_o  out  32  result to ex_mem
stallreq  out  1  hold IF/ID/ID_EX; EX is busy

Behaviour:
- Clock and reset: clk; reset rst, synchronous, active-high.
- While rst=1:
  - wd_o=0, wreg_o=0, wdata_o=0, stallreq=0.
  - At the edge: HI=LO=0, FSM=IDLE, counter=0.
- Non-divide results are combinational from the inputs (0-cycle latency); ex_mem registers them.
- wd_o=wd_i. wreg_o=wreg_i, forced 0 when flush=1.
- alusel LOGIC: AND/OR/XOR/NOR.
- alusel SHIFT: SLL/SRL/SRA of reg2_i by reg1_i[4:0]. SRA sign-fills.
- alusel ARITH:
  - ADDU/SUBU: mod 2^32, no overflow trap.
  - SLT: signed compare. SLTU: unsigned compare. Result 0 or 1.
- alusel MOVE: MFHI -> HI, MFLO -> LO.
- MTHI/MTLO: HI<=reg1_i or LO<=reg1_i at the clock edge; wdata_o=0.
- MULT/MULTU: single-cycle 64-bit product (signed/unsigned); {HI,LO}<=product at the edge.
- HI/LO update at the end of the EX cycle. An MFHI/MFLO in the following cycle sees the new value; no forwarding is needed.
- An unknown aluop/alusel gives wdata_o=0 and leaves HI/LO unchanged.
- Divider FSM states: IDLE, BUSY, DONE.
  - IDLE:
    - On DIV/DIVU with flush=0: stallreq=1.
    - If divisor==0, next state is DONE with the zero-divide result latched.
    - Otherwise latch |dividend| and |divisor| (raw values for DIVU), the sign flags, counter=0; next state BUSY.
  - BUSY: stallreq=1. One restoring-subtract step per cycle; counter++. After 32 steps (counter==31 at the edge), next state is DONE.
  - DONE:
    - stallreq=0.
    - Apply signs for DIV: quotient is negated if the operand signs differ; remainder takes the dividend sign.
    - HI<=remainder, LO<=quotient at the edge; next state IDLE.
- Divide latency: 34 EX cycles (1 IDLE + 32 BUSY + 1 DONE), with stallreq high for the first 33.
- Zero divide latency: 2 cycles.
- Zero-divide result: LO=32'hFFFF_FFFF, HI=dividend. Same for DIV and DIVU.
- A DIV immediately following a DIV is a new instruction: IDLE restarts normally.
- flush in any state:
  - Next state IDLE, stallreq=0 in that cycle, HI/LO unchanged.
  - Flush has priority over DONE's write.
- rst mid-divide: per the reset rule above; no HI/LO write.
- Inputs must stay stable while stallreq=1 (upstream guarantee). The FSM uses latched operands, not the live inputs.

Decomposition:
- Shared defines file:
  - bus widths `AluOpBus/`AluSelBus/`RegBus/`RegAddrBus/`DoubleRegBus.
  - all aluop/alusel encodings, including new MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
  - divider state encodings and `DivResultReady/`DivStart.
- One natural sub-module: div_unit (FSM, counter, 64-bit shift/remainder register, sign fixup). It exposes start, signed, opdata1/2, annul, result[63:0], ready.
- ex_stage keeps the ALU mux and the HI/LO registers.

Test Plan:
1. Reset held 2 cycles with ADDU inputs present -> wreg_o=0, wdata_o=0, stallreq=0; afterwards MFHI returns 0.
2. ADDU 0xFFFFFFFF+1 -> wdata_o=0. SLT -1,1 -> 1. SLTU -1,1 -> 0. SRA 0x80000000 by 4 -> 0xF8000000.
3. MULT -2*3, then MFHI, then MFLO in consecutive cycles -> 0xFFFFFFFF, then 0xFFFFFFFA.
4. DIV -7/2 held under stallreq:
   - stallreq high exactly 33 cycles, low on the 34th.
   - then MFLO -> 0xFFFFFFFD, MFHI -> 0xFFFFFFFF.
5. DIVU 100/0 -> stallreq high 1 cycle; LO=0xFFFFFFFF, HI=100.
6. DIVU 10/3 with flush in cycle 10 -> FSM IDLE next cycle, stallreq=0, HI/LO unchanged. A following DIVU 10/3 with no flush -> LO=3, HI=1.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared definitions for the MIPS execute stage.
//   Bus widths, aluop/alusel encodings (including the HI/LO, multiply and
//   divide operations), divider state encoding and divider handshake levels,
//   plus a small helper that takes the magnitude of a two's-complement word.
package ex_stage_pkg;

  // Bus widths
  localparam int ALU_OP_W   = 8;
  localparam int ALU_SEL_W  = 3;
  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int DREG_W     = 64;

  // One quotient bit per cycle, so the iteration count equals the operand width
  localparam int DIV_ITERS  = 32;

  // alusel: operation class
  localparam logic [ALU_SEL_W-1:0] SEL_NOP   = 3'b000;
  localparam logic [ALU_SEL_W-1:0] SEL_LOGIC = 3'b001;
  localparam logic [ALU_SEL_W-1:0] SEL_SHIFT = 3'b010;
  localparam logic [ALU_SEL_W-1:0] SEL_MOVE  = 3'b011;
  localparam logic [ALU_SEL_W-1:0] SEL_ARITH = 3'b100;

  // aluop: sub-operation
  localparam logic [ALU_OP_W-1:0] OP_NOP   = 8'b0000_0000;
  localparam logic [ALU_OP_W-1:0] OP_AND   = 8'b0010_0100;
  localparam logic [ALU_OP_W-1:0] OP_OR    = 8'b0010_0101;
  localparam logic [ALU_OP_W-1:0] OP_XOR   = 8'b0010_0110;
  localparam logic [ALU_OP_W-1:0] OP_NOR   = 8'b0010_0111;
  localparam logic [ALU_OP_W-1:0] OP_SLL   = 8'b0111_1100;
  localparam logic [ALU_OP_W-1:0] OP_SRL   = 8'b0000_0010;
  localparam logic [ALU_OP_W-1:0] OP_SRA   = 8'b0000_0011;
  localparam logic [ALU_OP_W-1:0] OP_SLT   = 8'b0010_1010;
  localparam logic [ALU_OP_W-1:0] OP_SLTU  = 8'b0010_1011;
  localparam logic [ALU_OP_W-1:0] OP_ADDU  = 8'b0010_0001;
  localparam logic [ALU_OP_W-1:0] OP_SUBU  = 8'b0010_0011;
  localparam logic [ALU_OP_W-1:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [ALU_OP_W-1:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [ALU_OP_W-1:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [ALU_OP_W-1:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [ALU_OP_W-1:0] OP_MULT  = 8'b0001_1000;
  localparam logic [ALU_OP_W-1:0] OP_MULTU = 8'b0001_1001;
  localparam logic [ALU_OP_W-1:0] OP_DIV   = 8'b0001_1010;
  localparam logic [ALU_OP_W-1:0] OP_DIVU  = 8'b0001_1011;

  // Divider FSM states
  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  // Divider handshake levels
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  // Magnitude of a word when treated as signed; raw value otherwise.
  // The most negative value maps to 2^31, which is still exact as unsigned.
  function automatic logic [REG_W-1:0] magnitude(input logic [REG_W-1:0] v,
                                                 input logic            as_signed);
    return (as_signed && v[REG_W-1]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_stage_div.sv
// div_unit: 32-iteration radix-2 restoring divider for DIV/DIVU.
//   clk, rst   : clock, synchronous active-high reset
//   start      : a divide instruction sits in EX
//   is_signed  : DIV (1) or DIVU (0)
//   opdata1/2  : dividend / divisor, sampled only when leaving IDLE
//   annul      : flush; abandons any divide and returns to IDLE
//   result     : {remainder, quotient} with signs applied, valid while ready
//   ready      : result may be written into HI/LO at this edge
//   stall      : the divide is still in progress, hold upstream stages
module div_unit
  import ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_signed,
  input  logic [REG_W-1:0]  opdata1,
  input  logic [REG_W-1:0]  opdata2,
  input  logic              annul,
  output logic [DREG_W-1:0] result,
  output logic              ready,
  output logic              stall
);

  div_state_e        state, state_next;
  logic [4:0]        count;
  logic [DREG_W-1:0] work;     // upper half: partial remainder, lower half: dividend shifting into quotient
  logic [REG_W-1:0]  divisor;
  logic              neg_quot;
  logic              neg_rem;
  logic [REG_W:0]    partial;
  logic [REG_W+1:0]  diff;
  logic [REG_W-1:0]  quot_fix;
  logic [REG_W-1:0]  rem_fix;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= DIV_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; annul overrides everything, including DONE
  always_comb begin
    state_next = state;
    if (annul) begin
      state_next = DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: if (start == DIV_START)
                    state_next = (opdata2 == '0) ? DIV_DONE : DIV_BUSY;
        DIV_BUSY: if (count == 5'(DIV_ITERS - 1)) state_next = DIV_DONE;
        DIV_DONE: state_next = DIV_IDLE;
        default:  state_next = DIV_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    stall = 1'b0;
    ready = DIV_RESULT_NOT_READY;
    case (state)
      DIV_IDLE: stall = (start == DIV_START) && !annul;
      DIV_BUSY: stall = !annul;
      DIV_DONE: ready = annul ? DIV_RESULT_NOT_READY : DIV_RESULT_READY;
      default:  stall = 1'b0;
    endcase
  end

  // One restoring step: shift the next dividend bit into the remainder and
  // try to subtract the divisor; a borrow in the top bit means "restore".
  assign partial = {work[DREG_W-1:REG_W], work[REG_W-1]};
  assign diff    = {1'b0, partial} - {2'b00, divisor};

  // Divider datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      work     <= '0;
      divisor  <= '0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if ((start == DIV_START) && !annul) begin
            count <= '0;
            if (opdata2 == '0) begin
              // Zero divisor: the final result is preloaded and passes unsigned
              work     <= {opdata1, 32'hFFFF_FFFF};
              neg_quot <= 1'b0;
              neg_rem  <= 1'b0;
            end else begin
              work     <= {{REG_W{1'b0}}, magnitude(opdata1, is_signed)};
              divisor  <= magnitude(opdata2, is_signed);
              neg_quot <= is_signed && (opdata1[REG_W-1] ^ opdata2[REG_W-1]);
              neg_rem  <= is_signed && opdata1[REG_W-1];
            end
          end
        end
        DIV_BUSY: begin
          if (!annul) begin
            count <= count + 5'd1;
            if (!diff[REG_W+1]) work <= {diff[REG_W-1:0], work[REG_W-2:0], 1'b1};
            else                work <= {partial[REG_W-1:0], work[REG_W-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  // Quotient is negative when operand signs differ; remainder follows the dividend
  assign quot_fix = neg_quot ? (~work[REG_W-1:0] + 32'd1) : work[REG_W-1:0];
  assign rem_fix  = neg_rem  ? (~work[DREG_W-1:REG_W] + 32'd1) : work[DREG_W-1:REG_W];
  assign result   = {rem_fix, quot_fix};

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage MIPS pipeline.
//   clk, rst          : clock, synchronous active-high reset
//   flush             : annul the instruction in EX (also aborts a divide)
//   aluop_i, alusel_i : sub-operation and operation class
//   reg1_i, reg2_i    : operands (shift amount in reg1_i[4:0], source in reg2_i)
//   wd_i, wreg_i      : destination register and write enable
//   wd_o, wreg_o      : destination info forwarded to ex_mem
//   wdata_o           : combinational result forwarded to ex_mem
//   stallreq          : hold IF/ID/ID_EX while a divide is in progress
// Owns the architectural HI/LO registers; divides run in div_unit.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [ALU_OP_W-1:0]   aluop_i,
  input  logic [ALU_SEL_W-1:0]  alusel_i,
  input  logic [REG_W-1:0]      reg1_i,
  input  logic [REG_W-1:0]      reg2_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [REG_W-1:0]      wdata_o,
  output logic                  stallreq
);

  logic [REG_W-1:0]  hi;
  logic [REG_W-1:0]  lo;
  logic [REG_W-1:0]  alu_res;
  logic [DREG_W-1:0] prod_s;
  logic [DREG_W-1:0] prod_u;
  logic              is_div;
  logic              div_start;
  logic [DREG_W-1:0] div_result;
  logic              div_ready;
  logic              div_stall;

  // Both operands are widened to 64 bits first so the low 64 bits of the
  // product are exact for either signedness.
  assign prod_s = $signed({{REG_W{reg1_i[REG_W-1]}}, reg1_i}) *
                  $signed({{REG_W{reg2_i[REG_W-1]}}, reg2_i});
  assign prod_u = {{REG_W{1'b0}}, reg1_i} * {{REG_W{1'b0}}, reg2_i};

  assign is_div    = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
  assign div_start = is_div ? DIV_START : DIV_STOP;

  div_unit u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .is_signed (aluop_i == OP_DIV),
    .opdata1   (reg1_i),
    .opdata2   (reg2_i),
    .annul     (flush),
    .result    (div_result),
    .ready     (div_ready),
    .stall     (div_stall)
  );

  // Result mux; any aluop not belonging to the selected class yields 0
  always_comb begin
    alu_res = '0;
    case (alusel_i)
      SEL_LOGIC: begin
        case (aluop_i)
          OP_AND:  alu_res = reg1_i & reg2_i;
          OP_OR:   alu_res = reg1_i | reg2_i;
          OP_XOR:  alu_res = reg1_i ^ reg2_i;
          OP_NOR:  alu_res = ~(reg1_i | reg2_i);
          default: alu_res = '0;
        endcase
      end
      SEL_SHIFT: begin
        case (aluop_i)
          OP_SLL:  alu_res = reg2_i << reg1_i[4:0];
          OP_SRL:  alu_res = reg2_i >> reg1_i[4:0];
          OP_SRA:  alu_res = $signed(reg2_i) >>> reg1_i[4:0];
          default: alu_res = '0;
        endcase
      end
      SEL_ARITH: begin
        case (aluop_i)
          OP_ADDU: alu_res = reg1_i + reg2_i;
          OP_SUBU: alu_res = reg1_i - reg2_i;
          OP_SLT:  alu_res = {31'b0, $signed(reg1_i) < $signed(reg2_i)};
          OP_SLTU: alu_res = {31'b0, reg1_i < reg2_i};
          default: alu_res = '0;
        endcase
      end
      SEL_MOVE: begin
        case (aluop_i)
          OP_MFHI: alu_res = hi;
          OP_MFLO: alu_res = lo;
          default: alu_res = '0;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  // HI/LO update at the end of the EX cycle; a flushed instruction writes nothing
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (!flush) begin
      case (aluop_i)
        OP_MTHI:  hi <= reg1_i;
        OP_MTLO:  lo <= reg1_i;
        OP_MULT:  {hi, lo} <= prod_s;
        OP_MULTU: {hi, lo} <= prod_u;
        OP_DIV, OP_DIVU: begin
          if (div_ready == DIV_RESULT_READY) {hi, lo} <= div_result;
        end
        default: ;
      endcase
    end
  end

  assign wd_o     = rst ? '0 : wd_i;
  assign wreg_o   = !rst && !flush && wreg_i;
  assign wdata_o  = rst ? '0 : alu_res;
  assign stallreq = !rst && div_stall;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: self-checking bench for ex_stage.
//   Table of directed ALU vectors, hand-written HI/LO, multiply and divide
//   sequences (including zero divide and flush corners), then randomized
//   operations checked against an arithmetic reference model of HI/LO.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq;

  int vectors;
  int miscompares;
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  typedef struct {
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        fl;
    logic        chk_data;
    logic [31:0] exp_data;
    logic        exp_wreg;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  ex_stage dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .aluop_i  (aluop_i),
    .alusel_i (alusel_i),
    .reg1_i   (reg1_i),
    .reg2_i   (reg2_i),
    .wd_i     (wd_i),
    .wreg_i   (wreg_i),
    .wd_o     (wd_o),
    .wreg_o   (wreg_o),
    .wdata_o  (wdata_o),
    .stallreq (stallreq)
  );

  // Global guard so a stuck bench still ends
  initial begin
    #500000;
    $display("[TB] FAIL timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [7:0] op, input logic [2:0] sel,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] wd, input logic wr, input logic fl);
    aluop_i  = op;
    alusel_i = sel;
    reg1_i   = a;
    reg2_i   = b;
    wd_i     = wd;
    wreg_i   = wr;
    flush    = fl;
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic add_vec(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic fl, input logic chk,
                         input logic [31:0] exp_data, input logic exp_wreg);
    vec_t v;
    v.op = op; v.sel = sel; v.a = a; v.b = b; v.fl = fl;
    v.chk_data = chk; v.exp_data = exp_data; v.exp_wreg = exp_wreg;
    vecs.push_back(v);
  endtask

  // Runs a divide held under stallreq; returns how many cycles stallreq was high
  task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int flush_at, output int stall_cycles);
    bit done;
    done = 1'b0;
    stall_cycles = 0;
    for (int c = 1; c <= 60 && !done; c++) begin
      apply_stimulus(op, SEL_NOP, a, b, 5'd0, 1'b0, c == flush_at);
      if (stallreq === 1'b1) stall_cycles++;
      else done = 1'b1;
      step();
    end
    flush = 1'b0;
  endtask

  task automatic check_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    apply_stimulus(OP_MFHI, SEL_MOVE, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0);
    check_output({tag, " MFHI"}, wdata_o, exp_hi);
    step();
    apply_stimulus(OP_MFLO, SEL_MOVE, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0);
    check_output({tag, " MFLO"}, wdata_o, exp_lo);
    step();
  endtask

  // Reference result written from the instruction semantics
  function automatic logic [31:0] ref_alu(input logic [7:0] op, input logic [2:0] sel,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] hv, input logic [31:0] lv);
    int sa, sb, sh;
    logic [31:0] r;
    sa = int'(a);
    sb = int'(b);
    sh = int'(a[4:0]);
    r = 32'h0;
    if (sel == SEL_LOGIC) begin
      if (op == OP_AND) r = a & b;
      if (op == OP_OR)  r = a | b;
      if (op == OP_XOR) r = a ^ b;
      if (op == OP_NOR) r = ~(a | b);
    end else if (sel == SEL_SHIFT) begin
      if (op == OP_SLL) r = b << sh;
      if (op == OP_SRL) r = b >> sh;
      if (op == OP_SRA) r = 32'(sb >>> sh);
    end else if (sel == SEL_ARITH) begin
      if (op == OP_ADDU) r = 32'(sa + sb);
      if (op == OP_SUBU) r = 32'(sa - sb);
      if (op == OP_SLT)  r = (sa < sb) ? 32'd1 : 32'd0;
      if (op == OP_SLTU) r = (a < b) ? 32'd1 : 32'd0;
    end else if (sel == SEL_MOVE) begin
      if (op == OP_MFHI) r = hv;
      if (op == OP_MFLO) r = lv;
    end
    return r;
  endfunction

  // HI/LO model for multiply and divide
  task automatic model_hilo(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p;
    longint unsigned pu;
    int q, rm;
    case (op)
      OP_MTHI: hi_m = a;
      OP_MTLO: lo_m = a;
      OP_MULT: begin
        p = longint'(int'(a)) * longint'(int'(b));
        hi_m = p[63:32];
        lo_m = p[31:0];
      end
      OP_MULTU: begin
        pu = longint'({32'h0, a}) * longint'({32'h0, b});
        hi_m = pu[63:32];
        lo_m = pu[31:0];
      end
      OP_DIV, OP_DIVU: begin
        if (b == 32'h0) begin
          hi_m = a;
          lo_m = 32'hFFFF_FFFF;
        end else if (op == OP_DIV) begin
          q  = int'(a) / int'(b);
          rm = int'(a) % int'(b);
          hi_m = rm;
          lo_m = q;
        end else begin
          hi_m = a % b;
          lo_m = a / b;
        end
      end
      default: ;
    endcase
  endtask

  task automatic pick_op(input int k, output logic [7:0] op, output logic [2:0] sel);
    case (k)
      0:  begin op = OP_AND;   sel = SEL_LOGIC; end
      1:  begin op = OP_OR;    sel = SEL_LOGIC; end
      2:  begin op = OP_XOR;   sel = SEL_LOGIC; end
      3:  begin op = OP_NOR;   sel = SEL_LOGIC; end
      4:  begin op = OP_SLL;   sel = SEL_SHIFT; end
      5:  begin op = OP_SRL;   sel = SEL_SHIFT; end
      6:  begin op = OP_SRA;   sel = SEL_SHIFT; end
      7:  begin op = OP_ADDU;  sel = SEL_ARITH; end
      8:  begin op = OP_SUBU;  sel = SEL_ARITH; end
      9:  begin op = OP_SLT;   sel = SEL_ARITH; end
      10: begin op = OP_SLTU;  sel = SEL_ARITH; end
      11: begin op = OP_MFHI;  sel = SEL_MOVE;  end
      12: begin op = OP_MFLO;  sel = SEL_MOVE;  end
      13: begin op = OP_MTHI;  sel = SEL_NOP;   end
      14: begin op = OP_MTLO;  sel = SEL_NOP;   end
      15: begin op = OP_MULT;  sel = SEL_NOP;   end
      16: begin op = OP_MULTU; sel = SEL_NOP;   end
      default: begin op = 8'hFF; sel = SEL_LOGIC; end
    endcase
  endtask

  initial begin
    int n;
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] a, b, exp;
    logic [4:0]  wd;
    logic        wr, fl;

    vectors = 0;
    miscompares = 0;
    rst = 1'b1;

    // Reset held two cycles with an ADDU present
    apply_stimulus(OP_ADDU, SEL_ARITH, 32'd1, 32'd2, 5'd7, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      check_output($sformatf("reset%0d wreg", i), {31'b0, wreg_o}, 32'd0);
      check_output($sformatf("reset%0d wdata", i), wdata_o, 32'd0);
      check_output($sformatf("reset%0d stall", i), {31'b0, stallreq}, 32'd0);
      check_output($sformatf("reset%0d wd", i), {27'b0, wd_o}, 32'd0);
    end
    rst = 1'b0;

    // HI written, then cleared by reset
    apply_stimulus(OP_MTHI, SEL_NOP, 32'h0000_1234, 32'h0, 5'd0, 1'b0, 1'b0);
    check_output("MTHI wdata", wdata_o, 32'd0);
    step();
    apply_stimulus(OP_MFHI, SEL_MOVE, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0);
    check_output("MFHI after MTHI", wdata_o, 32'h0000_1234);
    rst = 1'b1;
    #1;
    check_output("MFHI under reset", wdata_o, 32'd0);
    step();
    rst = 1'b0;
    hi_m = 32'h0;
    lo_m = 32'h0;
    check_hilo("post-reset", 32'h0, 32'h0);

    // Directed ALU table
    add_vec(OP_ADDU, SEL_ARITH, 32'hFFFF_FFFF, 32'h1,         1'b0, 1'b1, 32'h0,         1'b1);
    add_vec(OP_SLT,  SEL_ARITH, 32'hFFFF_FFFF, 32'h1,         1'b0, 1'b1, 32'h1,         1'b1);
    add_vec(OP_SLTU, SEL_ARITH, 32'hFFFF_FFFF, 32'h1,         1'b0, 1'b1, 32'h0,         1'b1);
    add_vec(OP_SRA,  SEL_SHIFT, 32'h4,         32'h8000_0000, 1'b0, 1'b1, 32'hF800_0000, 1'b1);
    add_vec(OP_SRL,  SEL_SHIFT, 32'h4,         32'h8000_0000, 1'b0, 1'b1, 32'h0800_0000, 1'b1);
    add_vec(OP_SLL,  SEL_SHIFT, 32'h24,        32'h0000_000F, 1'b0, 1'b1, 32'h0000_00F0, 1'b1);
    add_vec(OP_AND,  SEL_LOGIC, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1'b1, 32'hF000_F000, 1'b1);
    add_vec(OP_OR,   SEL_LOGIC, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1'b1, 32'hFFF0_FFF0, 1'b1);
    add_vec(OP_XOR,  SEL_LOGIC, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1'b1, 32'h0FF0_0FF0, 1'b1);
    add_vec(OP_NOR,  SEL_LOGIC, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1'b1, 32'h000F_000F, 1'b1);
    add_vec(OP_SUBU, SEL_ARITH, 32'h0,         32'h1,         1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    add_vec(OP_SLT,  SEL_ARITH, 32'h1,         32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0,         1'b1);
    add_vec(OP_ADDU, 3'b111,    32'h5,         32'h6,         1'b0, 1'b1, 32'h0,         1'b1);
    add_vec(OP_SLL,  SEL_LOGIC, 32'h1,         32'h1,         1'b0, 1'b1, 32'h0,         1'b1);
    add_vec(OP_ADDU, SEL_ARITH, 32'h1,         32'h2,         1'b1, 1'b0, 32'h0,         1'b0);
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].op, vecs[i].sel, vecs[i].a, vecs[i].b, 5'(i), 1'b1, vecs[i].fl);
      if (vecs[i].chk_data) check_output($sformatf("vec%0d wdata", i), wdata_o, vecs[i].exp_data);
      check_output($sformatf("vec%0d wreg", i), {31'b0, wreg_o}, {31'b0, vecs[i].exp_wreg});
      check_output($sformatf("vec%0d wd", i), {27'b0, wd_o}, 32'(i % 32));
      check_output($sformatf("vec%0d stall", i), {31'b0, stallreq}, 32'd0);
      step();
    end
    flush = 1'b0;

    // MULT -2*3, then MFHI and MFLO back to back
    apply_stimulus(OP_MULT, SEL_NOP, 32'hFFFF_FFFE, 32'd3, 5'd0, 1'b0, 1'b0);
    check_output("MULT wdata", wdata_o, 32'd0);
    step();
    check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    // DIV -7/2
    run_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, n);
    check_output("div -7/2 stall cycles", n, 32'd33);
    check_hilo("div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // DIVU 100/0
    run_div(OP_DIVU, 32'd100, 32'd0, 0, n);
    check_output("divu 100/0 stall cycles", n, 32'd1);
    check_hilo("divu 100/0", 32'd100, 32'hFFFF_FFFF);

    // DIVU 10/3 flushed in cycle 10, then rerun
    run_div(OP_DIVU, 32'd10, 32'd3, 10, n);
    check_output("divu flushed stall cycles", n, 32'd9);
    check_hilo("after flush", 32'd100, 32'hFFFF_FFFF);
    run_div(OP_DIVU, 32'd10, 32'd3, 0, n);
    check_output("divu 10/3 stall cycles", n, 32'd33);
    check_hilo("divu 10/3", 32'd1, 32'd3);

    // Flush on the DONE cycle beats the HI/LO write
    apply_stimulus(OP_MTHI, SEL_NOP, 32'h0000_CAFE, 32'h0, 5'd0, 1'b0, 1'b0);
    step();
    apply_stimulus(OP_MTLO, SEL_NOP, 32'h0000_BEEF, 32'h0, 5'd0, 1'b0, 1'b0);
    step();
    run_div(OP_DIV, 32'd50, 32'd7, 34, n);
    check_output("div flushed at done stall cycles", n, 32'd33);
    check_hilo("flush at done", 32'h0000_CAFE, 32'h0000_BEEF);

    // Flush in the first (IDLE) cycle never raises stallreq
    run_div(OP_DIV, 32'd9, 32'd2, 1, n);
    check_output("div flushed at idle stall cycles", n, 32'd0);
    check_hilo("flush at idle", 32'h0000_CAFE, 32'h0000_BEEF);

    // Signed zero divide, then back-to-back DIVs
    run_div(OP_DIV, 32'hFFFF_FFFB, 32'd0, 0, n);
    check_output("div -5/0 stall cycles", n, 32'd1);
    run_div(OP_DIV, 32'd20, 32'hFFFF_FFFA, 0, n);
    check_output("div 20/-6 stall cycles", n, 32'd33);
    check_hilo("div 20/-6", 32'd2, 32'hFFFF_FFFD);
    hi_m = 32'd2;
    lo_m = 32'hFFFF_FFFD;

    // Randomized single-cycle operations against the model
    for (int i = 0; i < 300; i++) begin
      pick_op(int'($urandom_range(0, 17)), op, sel);
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 4) == 0) b = a;
      wd = 5'($urandom);
      wr = 1'($urandom);
      fl = ($urandom_range(0, 9) == 0);
      apply_stimulus(op, sel, a, b, wd, wr, fl);
      exp = ref_alu(op, sel, a, b, hi_m, lo_m);
      if (!fl) check_output($sformatf("rand%0d wdata op=%h", i, op), wdata_o, exp);
      check_output($sformatf("rand%0d wreg", i), {31'b0, wreg_o}, {31'b0, wr && !fl});
      check_output($sformatf("rand%0d wd", i), {27'b0, wd_o}, {27'b0, wd});
      if (!fl) model_hilo(op, a, b);
      step();
    end
    flush = 1'b0;
    check_hilo("rand end", hi_m, lo_m);

    // Randomized divides
    for (int i = 0; i < 10; i++) begin
      op = ($urandom_range(0, 1) == 0) ? OP_DIV : OP_DIVU;
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'h0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: b = $urandom;
      endcase
      if (op == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd2;
      run_div(op, a, b, 0, n);
      check_output($sformatf("rdiv%0d stall cycles", i), n, (b == 32'h0) ? 32'd1 : 32'd33);
      model_hilo(op, a, b);
      check_hilo($sformatf("rdiv%0d", i), hi_m, lo_m);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
